// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a valid/ready input handshake.
// Define PARITY_EN to append an even-parity bit to every frame.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             out,
  output logic             busy,
  output logic             frame_end
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             out_q;
  logic             last_bit;
  logic             accept;
`ifdef PARITY_EN
  logic             par;
`endif

  // cnt is the index of the bit currently on out
  assign last_bit = (state == S_SHIFT)
                 && (cnt == LAST);

`ifdef PARITY_EN
  assign frame_end = (state == S_PARITY);
`else
  assign frame_end = last_bit;
`endif

  assign ready_out = (state == S_IDLE)
                  || frame_end;
  assign accept    = valid_in && ready_out;
  assign busy      = (state != S_IDLE);
  assign out       = out_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      out_q <= 1'b0;
`ifdef PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      // MSB goes out directly; the rest waits in sreg
      state <= S_SHIFT;
      out_q <= data_in[WIDTH-1];
      sreg  <= {data_in[WIDTH-2:0], 1'b0};
      cnt   <= '0;
`ifdef PARITY_EN
      par   <= ^data_in;
`endif
    end else begin
      unique case (state)
        S_SHIFT: begin
          if (cnt == LAST) begin
`ifdef PARITY_EN
            state <= S_PARITY;
            out_q <= par;
`else
            state <= S_IDLE;
            out_q <= 1'b0;
`endif
          end else begin
            out_q <= sreg[WIDTH-1];
            sreg  <= sreg << 1;
            cnt   <= cnt + 1'b1;
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          state <= S_IDLE;
          out_q <= 1'b0;
        end
`endif
        default: begin
          state <= S_IDLE;
          out_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
